register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor to the pipeline's 2-read/1-write register file.
- Adds:
  - generic data width, address width and register count;
  - an optional write-to-read bypass;
  - a per-register pending-write scoreboard (busy bits plus a live count), so the ID stage detects RAW hazards without a separate hazard table.
- Sits between ID (reads, issue) and WB (writes).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 2**ADDR_W, number of implemented registers (≤ 2**ADDR_W).
- ZERO_REG, 1, when 1, register 0 is hardwired to zero and never marked busy.
- BYPASS, 1, when 1, a same-cycle WB write is forwarded to the read ports.

Ports:
- Clock, input, 1, rising-edge clock.
- Reset_n, input, 1, asynchronous active-low reset.
- Read_addr1, input, ADDR_W, read port 1 address.
- Read_addr2, input, ADDR_W, read port 2 address.
- Read_data1, output, DATA_W, read port 1 data (combinational).
- Read_data2, output, DATA_W, read port 2 data (combinational).
- Read_busy1, output, 1, register at Read_addr1 has an outstanding write.
- Read_busy2, output, 1, register at Read_addr2 has an outstanding write.
- Write_En, input, 1, WB write strobe.
- Write_addr, input, ADDR_W, WB destination.
- Write_data, input, DATA_W, WB data.
- Issue_En, input, 1, ID issues an instruction that will write Issue_addr.
- Issue_addr, input, ADDR_W, destination of the issued instruction.
- Flush, input, 1, pipeline flush; clears all busy bits.
- Busy_count, output, ADDR_W+1, number of busy registers (registered).

Behaviour:
- Reset:
  - Reset_n low asynchronously clears all registers, busy bits and Busy_count to 0.
  - Read_data and Read_busy therefore read 0 during reset.
- Write:
  - On the rising edge with Write_En=1, registers[Write_addr] <= Write_data.
  - The write is ignored if Write_addr ≥ NUM_REGS, or if ZERO_REG=1 and Write_addr=0.
  - Writes are performed regardless of Flush.
- Read:
  - Combinational.
  - Returns 0 for addr ≥ NUM_REGS, and for addr 0 when ZERO_REG=1.
  - If BYPASS=1, Write_En=1, Write_addr==Read_addrN and the write is legal, Read_dataN = Write_data in the same cycle.
  - Otherwise Read_dataN = stored value; the new value becomes visible the next cycle.
- Busy bits, updated on the rising edge. Per register r, priority order:
  1. Flush=1: busy[r] <= 0. Issue_En is ignored that cycle.
  2. Issue_En=1 and Issue_addr==r: busy[r] <= 1. The newer producer wins over a same-cycle WB clear.
  3. Write_En=1 and Write_addr==r: busy[r] <= 0.
  4. Otherwise hold.
- Issue to an illegal address (≥ NUM_REGS, or reg 0 with ZERO_REG=1) is ignored.
- Read_busyN:
  - Equals busy[Read_addrN].
  - With BYPASS=1, it is forced to 0 when a legal same-cycle write to Read_addrN is present, because the data is forwarded.
  - Illegal addresses always read not-busy.
- Busy_count is maintained incrementally:
  - Flush: becomes 0.
  - Otherwise next = count + set − clr, where:
    - set = 1 if a legal issue targets a currently non-busy register;
    - clr = 1 if a legal write clears a busy register that is not re-issued the same cycle.
  - Issue and write to the same busy register in one cycle: count unchanged.
  - Busy_count must always equal the popcount of the busy bits.
  - It can never exceed NUM_REGS or underflow.
  - A write to a non-busy register does not change the count.
- Latency:
  - Write visible on the read port 1 cycle later (0 cycles with BYPASS).
  - Busy set/clear visible 1 cycle after the edge.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/ADDR_W constants;
  - a function legal_addr(addr, NUM_REGS, ZERO_REG) shared by the read, write and issue paths.
- Sub-module rf_scoreboard holds the busy bit vector and Busy_count (Flush, Issue, Write inputs; busy vector and count outputs).
- The top level holds the storage array and the bypass muxes.

Test Plan:
- Reset and reads:
  - Stimulus: assert Reset_n=0 mid-run after writing reg5=0xDEADBEEF.
  - Response: Read_data1(5)=0, Busy_count=0, all Read_busy=0, asynchronously, before the next edge.
- Zero register:
  - Stimulus: write reg0=0x1234 and issue reg0.
  - Response: Read_data(0)=0, Read_busy=0, Busy_count stays 0.
- Bypass:
  - Stimulus: BYPASS=1, Write_En with reg7=0xA5A5A5A5, Read_addr2=7, same cycle.
  - Response: Read_data2=0xA5A5A5A5 immediately.
  - With BYPASS=0, Read_data2 shows the old value, then 0xA5A5A5A5 next cycle.
- Scoreboard:
  - Stimulus: issue r3, issue r4, then write r3.
  - Response: Busy_count 1, then 2, then 1; Read_busy(r3)=1 until the write cycle.
  - With BYPASS=1, Read_busy(r3)=0 in the write cycle itself.
- Collision:
  - Stimulus: r9 busy; Issue_addr=9 and Write_addr=9 in the same cycle.
  - Response: r9 remains busy, Busy_count unchanged, register holds Write_data.
- Flush:
  - Stimulus: issue r1, r2, r3 (count=3); Flush=1 together with Issue_addr=4 and Write to r1.
  - Response: next cycle all busy=0, Busy_count=0, r4 not busy, r1 updated with Write_data.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the address-legality rule used by the register file's read, write and issue paths.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // An address is usable when it maps to an implemented register that is not the hardwired zero.
  function automatic logic legal_addr(input logic [31:0] addr, input int unsigned num_regs,
                                      input bit zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an incrementally maintained busy count.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_addr_i,
  input  logic                write_valid_i,
  input  logic [ADDR_W-1:0]   write_addr_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [ADDR_W:0]     count_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] issue_hit, write_hit;
  logic [ADDR_W:0]     count_q, count_d;
  logic                set, clr;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    issue_hit = '0;
    write_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      issue_hit[r] = issue_valid_i && (issue_addr_i == ADDR_W'(r));
      write_hit[r] = write_valid_i && (write_addr_i == ADDR_W'(r));
    end
  end

  // A same-cycle issue beats the WB clear: the newer producer still owns the register.
  assign set = |(issue_hit & ~busy_q);
  assign clr = |(write_hit & busy_q & ~issue_hit);

  always_comb begin
    busy_d  = (busy_q & ~write_hit) | issue_hit;
    count_d = count_q + (ADDR_W + 1)'(set) - (ADDR_W + 1)'(clr);
    if (flush_i) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/register_file_sb.sv
// 2-read/1-write register file with optional WB-to-ID bypass and a per-register pending-write scoreboard.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Read_addr1,
  input  logic [ADDR_W-1:0] Read_addr2,
  output logic [DATA_W-1:0] Read_data1,
  output logic [DATA_W-1:0] Read_data2,
  output logic              Read_busy1,
  output logic              Read_busy2,
  input  logic              Write_En,
  input  logic [ADDR_W-1:0] Write_addr,
  input  logic [DATA_W-1:0] Write_data,
  input  logic              Issue_En,
  input  logic [ADDR_W-1:0] Issue_addr,
  input  logic              Flush,
  output logic [ADDR_W:0]   Busy_count
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_legal, iss_legal, rd_legal1, rd_legal2;
  logic                fwd1, fwd2, busy_at1, busy_at2;
  logic [DATA_W-1:0]   stored1, stored2;

  assign wr_legal  = Write_En && legal_addr(32'(Write_addr), NUM_REGS, ZR);
  assign iss_legal = Issue_En && legal_addr(32'(Issue_addr), NUM_REGS, ZR);
  assign rd_legal1 = legal_addr(32'(Read_addr1), NUM_REGS, ZR);
  assign rd_legal2 = legal_addr(32'(Read_addr2), NUM_REGS, ZR);

  // NOTE: the storage array is reset with the rest of the state, so it is built from flops, not RAM.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (wr_legal) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (Write_addr == ADDR_W'(r)) regs_q[r] <= Write_data;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .flush_i       (Flush),
    .issue_valid_i (iss_legal),
    .issue_addr_i  (Issue_addr),
    .write_valid_i (wr_legal),
    .write_addr_i  (Write_addr),
    .busy_o        (busy),
    .count_o       (Busy_count)
  );

  always_comb begin
    stored1  = '0;
    stored2  = '0;
    busy_at1 = 1'b0;
    busy_at2 = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (Read_addr1 == ADDR_W'(r)) begin
        stored1  = regs_q[r];
        busy_at1 = busy[r];
      end
      if (Read_addr2 == ADDR_W'(r)) begin
        stored2  = regs_q[r];
        busy_at2 = busy[r];
      end
    end
  end

  // A forwarded write both supplies the data and retires the hazard in the same cycle.
  assign fwd1 = BP && wr_legal && (Write_addr == Read_addr1);
  assign fwd2 = BP && wr_legal && (Write_addr == Read_addr2);

  assign Read_data1 = !rd_legal1 ? '0 : (fwd1 ? Write_data : stored1);
  assign Read_data2 = !rd_legal2 ? '0 : (fwd2 ? Write_data : stored2);
  assign Read_busy1 = rd_legal1 && !fwd1 && busy_at1;
  assign Read_busy2 = rd_legal2 && !fwd2 && busy_at2;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: a bypassing 32-entry instance and a non-bypassing 16-entry instance.
module tb_register_file_sb;

  localparam int SIG_RD1 = 0, SIG_RD2 = 1, SIG_B1 = 2, SIG_B2 = 3, SIG_CNT = 4;

  typedef struct {
    int          cyc;
    int          dut;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic        wr_en, iss_en, flush;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, b_b1, b_b2;
  logic [5:0]  a_cnt, b_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  register_file_sb #(.NUM_REGS(32), .BYPASS(1)) u_dut_a (
    .Clock(clk), .Reset_n(rst_n),
    .Read_addr1(rd_addr1), .Read_addr2(rd_addr2),
    .Read_data1(a_rd1), .Read_data2(a_rd2),
    .Read_busy1(a_b1), .Read_busy2(a_b2),
    .Write_En(wr_en), .Write_addr(wr_addr), .Write_data(wr_data),
    .Issue_En(iss_en), .Issue_addr(iss_addr), .Flush(flush),
    .Busy_count(a_cnt)
  );

  register_file_sb #(.NUM_REGS(16), .BYPASS(0)) u_dut_b (
    .Clock(clk), .Reset_n(rst_n),
    .Read_addr1(rd_addr1), .Read_addr2(rd_addr2),
    .Read_data1(b_rd1), .Read_data2(b_rd2),
    .Read_busy1(b_b1), .Read_busy2(b_b2),
    .Write_En(wr_en), .Write_addr(wr_addr), .Write_data(wr_data),
    .Issue_En(iss_en), .Issue_addr(iss_addr), .Flush(flush),
    .Busy_count(b_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] actual(input int dut, input int sig);
    logic [31:0] v;
    v = 32'hxxxx_xxxx;
    case (sig)
      SIG_RD1: v = (dut == 0) ? a_rd1 : b_rd1;
      SIG_RD2: v = (dut == 0) ? a_rd2 : b_rd2;
      SIG_B1:  v = {31'd0, (dut == 0) ? a_b1 : b_b1};
      SIG_B2:  v = {31'd0, (dut == 0) ? a_b2 : b_b2};
      SIG_CNT: v = {26'd0, (dut == 0) ? a_cnt : b_cnt};
      default: v = 32'hxxxx_xxxx;
    endcase
    return v;
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check($sformatf("%s_dut%s", e.name, (e.dut == 0) ? "A" : "B"), actual(e.dut, e.sig), e.exp);
    end
  end

  task automatic expect_one(input int dut, input int sig, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.sig = sig; e.exp = v; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_both(input int sig, input logic [31:0] v, input string name);
    expect_one(0, sig, v, name);
    expect_one(1, sig, v, name);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_issue(input logic [4:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; iss_addr = '0;
    wr_data = '0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd7;
    expect_both(SIG_RD1, 0, "rst_rd1"); expect_both(SIG_RD2, 0, "rst_rd2");
    expect_both(SIG_B1, 0, "rst_b1");   expect_both(SIG_CNT, 0, "rst_cnt");

    nxt(); do_write(5, 32'hDEAD_BEEF);
    expect_one(0, SIG_RD1, 32'hDEAD_BEEF, "wr5_bypass"); expect_one(1, SIG_RD1, 0, "wr5_old");
    nxt(); do_issue(5);
    expect_both(SIG_RD1, 32'hDEAD_BEEF, "wr5_visible"); expect_both(SIG_B1, 0, "iss5_not_yet");
    nxt();
    expect_both(SIG_B1, 1, "iss5_busy"); expect_both(SIG_CNT, 1, "iss5_cnt");
    nxt(); rst_n = 1'b0;
    expect_both(SIG_RD1, 0, "async_rst_rd1"); expect_both(SIG_B1, 0, "async_rst_b1");
    expect_both(SIG_B2, 0, "async_rst_b2");   expect_both(SIG_CNT, 0, "async_rst_cnt");
    nxt(); rst_n = 1'b1;
    expect_both(SIG_RD1, 0, "post_rst_rd1"); expect_both(SIG_CNT, 0, "post_rst_cnt");

    nxt(); rd_addr1 = 5'd0; do_write(0, 32'h1234); do_issue(0);
    expect_both(SIG_RD1, 0, "zero_wr_rd"); expect_both(SIG_B1, 0, "zero_iss_b");
    nxt();
    expect_both(SIG_RD1, 0, "zero_rd"); expect_both(SIG_B1, 0, "zero_b"); expect_both(SIG_CNT, 0, "zero_cnt");

    nxt(); do_write(7, 32'hA5A5_A5A5);
    expect_one(0, SIG_RD2, 32'hA5A5_A5A5, "byp_rd2"); expect_one(1, SIG_RD2, 0, "nobyp_rd2_old");
    nxt();
    expect_both(SIG_RD2, 32'hA5A5_A5A5, "rd2_next");

    nxt(); rd_addr1 = 5'd3; rd_addr2 = 5'd4; do_issue(3);
    expect_both(SIG_CNT, 0, "sb_cnt0"); expect_both(SIG_B1, 0, "sb_r3_not_yet");
    nxt(); do_issue(4);
    expect_both(SIG_CNT, 1, "sb_cnt1"); expect_both(SIG_B1, 1, "sb_r3_busy"); expect_both(SIG_B2, 0, "sb_r4_not_yet");
    nxt(); do_write(3, 32'h33);
    expect_both(SIG_CNT, 2, "sb_cnt2"); expect_both(SIG_B2, 1, "sb_r4_busy");
    expect_one(0, SIG_B1, 0, "sb_r3_fwd_free"); expect_one(1, SIG_B1, 1, "sb_r3_wr_busy");
    expect_one(0, SIG_RD1, 32'h33, "sb_r3_fwd_data"); expect_one(1, SIG_RD1, 0, "sb_r3_old");
    nxt();
    expect_both(SIG_CNT, 1, "sb_cnt_after_wr"); expect_both(SIG_B1, 0, "sb_r3_free");
    expect_both(SIG_B2, 1, "sb_r4_still"); expect_both(SIG_RD1, 32'h33, "sb_r3_data");

    nxt(); rd_addr1 = 5'd9; do_issue(9);
    expect_both(SIG_CNT, 1, "col_pre_cnt"); expect_both(SIG_B1, 0, "col_pre_b");
    nxt();
    expect_both(SIG_CNT, 2, "col_busy_cnt"); expect_both(SIG_B1, 1, "col_busy");
    nxt(); do_issue(9); do_write(9, 32'h99);
    expect_both(SIG_CNT, 2, "col_same_cnt");
    expect_one(0, SIG_B1, 0, "col_fwd_b"); expect_one(1, SIG_B1, 1, "col_b");
    expect_one(0, SIG_RD1, 32'h99, "col_fwd_rd"); expect_one(1, SIG_RD1, 0, "col_old_rd");
    nxt();
    expect_both(SIG_CNT, 2, "col_after_cnt"); expect_both(SIG_B1, 1, "col_still_busy");
    expect_both(SIG_RD1, 32'h99, "col_data");

    nxt(); do_issue(1);
    nxt(); do_issue(2); expect_both(SIG_CNT, 3, "fl_cnt3");
    nxt(); do_issue(3); expect_both(SIG_CNT, 4, "fl_cnt4");
    nxt(); rd_addr1 = 5'd1; rd_addr2 = 5'd6; flush = 1'b1; do_issue(6); do_write(1, 32'h11);
    expect_both(SIG_CNT, 5, "fl_cnt5"); expect_both(SIG_B2, 0, "fl_r6_pre");
    expect_one(0, SIG_B1, 0, "fl_r1_fwd"); expect_one(1, SIG_B1, 1, "fl_r1_busy");
    expect_one(0, SIG_RD1, 32'h11, "fl_r1_fwd_data"); expect_one(1, SIG_RD1, 0, "fl_r1_old");
    nxt();
    expect_both(SIG_CNT, 0, "fl_cnt0"); expect_both(SIG_B1, 0, "fl_r1_free");
    expect_both(SIG_B2, 0, "fl_r6_ignored"); expect_both(SIG_RD1, 32'h11, "fl_r1_data");

    nxt(); rd_addr1 = 5'd20; do_write(20, 32'h2020); do_issue(20);
    expect_one(0, SIG_RD1, 32'h2020, "hi_fwd"); expect_one(1, SIG_RD1, 0, "hi_illegal_rd");
    expect_both(SIG_B1, 0, "hi_b_pre");
    nxt();
    expect_one(0, SIG_RD1, 32'h2020, "hi_data"); expect_one(1, SIG_RD1, 0, "hi_illegal_data");
    expect_one(0, SIG_B1, 1, "hi_busy");         expect_one(1, SIG_B1, 0, "hi_illegal_busy");
    expect_one(0, SIG_CNT, 1, "hi_cnt");         expect_one(1, SIG_CNT, 0, "hi_illegal_cnt");

    nxt(); rd_addr2 = 5'd2; do_write(2, 32'h22);
    expect_one(0, SIG_CNT, 1, "nb_wr_cnt"); expect_one(1, SIG_CNT, 0, "nb_wr_cnt");
    expect_one(0, SIG_RD2, 32'h22, "nb_fwd"); expect_one(1, SIG_RD2, 0, "nb_old");
    nxt();
    expect_one(0, SIG_CNT, 1, "nb_after_cnt"); expect_one(1, SIG_CNT, 0, "nb_after_cnt");
    expect_both(SIG_RD2, 32'h22, "nb_data");

    nxt(); nxt();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
